// File: rtl/rs_cmd_gen.sv
// rtl/rs_cmd_gen.sv - debounced, arbitrated S/R pulse generator with shadow Q for a clocked RS flip-flop
// Optional SET_PRIORITY_EN: a simultaneous set/clear resolves to a set pulse instead of a clear pulse.
module rs_cmd_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3,
  parameter int PULSE_LEN  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic clr_btn,
  output logic S,
  output logic R,
  output logic q_model,
  output logic busy,
  output logic conflict
);
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {IDLE, SET_P, CLR_P} state_e;

  // Channel index 0 is set, index 1 is clear throughout.
  logic [1:0]       sync1_q, sync2_q, deb_q, deb_d, pend_q, pend_d, rise;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  state_e           state_q;
  logic [PW-1:0]    pcnt_q;
  logic             s_q, r_q, qm_q, busy_q, conflict_q;
  logic             idle, go_set, go_clr;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise = deb_d & ~deb_q;
  end

  always_comb begin
    idle = (state_q == IDLE);
`ifdef SET_PRIORITY_EN
    go_set = idle & pend_q[0];
    go_clr = idle & pend_q[1] & ~pend_q[0];
`else
    go_clr = idle & pend_q[1];
    go_set = idle & pend_q[0] & ~pend_q[1];
`endif
    // Taking a request drops both flags, so the arbitration loser is discarded.
    pend_d = ((go_set | go_clr) ? 2'b00 : pend_q) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      pend_q     <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      state_q    <= IDLE;
      pcnt_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      qm_q       <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      sync1_q <= {clr_btn, set_btn};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      case (state_q)
        IDLE: begin
          pcnt_q <= '0;
          if (go_set || go_clr) begin
            state_q <= go_set ? SET_P : CLR_P;
            s_q     <= go_set;
            r_q     <= go_clr;
            qm_q    <= go_set;
            busy_q  <= 1'b1;
            if (&pend_q) conflict_q <= 1'b1;
          end
        end
        default: begin
          // Returning through IDLE guarantees a low cycle between pulses.
          if (pcnt_q == PULSE_LAST) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign q_model  = qm_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;
endmodule

// File: tb/tb_rs_cmd_gen.sv
// tb/tb_rs_cmd_gen.sv - scoreboard bench for rs_cmd_gen with a cycle-level behavioural model
// Honours SET_PRIORITY_EN in its arbitration model.
module tb_rs_cmd_gen;
  localparam int DEB = 4;
  localparam int PL  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_btn = 1'b0;
  logic clr_btn = 1'b0;
  logic S, R, q_model, busy, conflict;

  int checks = 0;
  int failures = 0;

  rs_cmd_gen #(.DEB_CYCLES(DEB), .CNT_W(3), .PULSE_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .clr_btn(clr_btn),
    .S(S), .R(R), .q_model(q_model), .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit kind;   // 1 = S pulse, 0 = R pulse
    int cyc;    // edge count (since reset release) at which the pulse starts
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: button seen two edges late, level accepted after DEB equal samples,
  // rising levels become requests, requests served once the previous pulse plus a gap is over.
  int cyc;
  bit h1 [2];
  bit h2 [2];
  bit last_sync [2];
  int run [2];
  bit mdeb [2];
  bit mp [2];
  bit mq, mconf;
  int free_at;

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0; free_at = 0; mq = 0; mconf = 0;
      for (int i = 0; i < 2; i++) begin
        h1[i] = 0; h2[i] = 0; last_sync[i] = 0; run[i] = 0; mdeb[i] = 0; mp[i] = 0;
      end
      exp_q.delete();
    end else begin
      bit raw [2];
      bit kind;
      cyc++;
      raw[0] = set_btn;
      raw[1] = clr_btn;
      if (cyc >= free_at && (mp[0] || mp[1])) begin
`ifdef SET_PRIORITY_EN
        kind = mp[0];
`else
        kind = !mp[1];
`endif
        if (mp[0] && mp[1]) mconf = 1;
        mq = kind;
        exp_q.push_back('{kind: kind, cyc: cyc});
        free_at = cyc + PL + 1;
        mp[0] = 0;
        mp[1] = 0;
      end
      for (int ch = 0; ch < 2; ch++) begin
        bit synced;
        synced = h2[ch];
        h2[ch] = h1[ch];
        h1[ch] = raw[ch];
        if (synced == last_sync[ch]) run[ch]++;
        else begin
          run[ch] = 1;
          last_sync[ch] = synced;
        end
        if (synced != mdeb[ch] && run[ch] >= DEB) begin
          mdeb[ch] = synced;
          if (synced) mp[ch] = 1;
        end
      end
    end
  end

  // Monitor: pops an expectation whenever a pulse begins; checks invariants every cycle.
  bit s_prev, r_prev;
  int hi_len;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_prev = 0; r_prev = 0; hi_len = 0;
    end else begin
      chk("s_and_r_exclusive", int'(S & R), 0);
      chk("busy_vs_pulse", int'(busy), int'(S | R));
      chk("q_model", int'(q_model), int'(mq));
      chk("conflict", int'(conflict), int'(mconf));
      if ((S && !s_prev) || (R && !r_prev)) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_s", int'(S), int'(e.kind));
          chk("pulse_start_cycle", cyc, e.cyc);
        end
      end
      if (S || R) hi_len++;
      else if (hi_len != 0) begin
        chk("pulse_length", hi_len, PL);
        hi_len = 0;
      end
      s_prev = S;
      r_prev = R;
    end
  end

  task automatic step(input bit s, input bit c, input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      set_btn = s;
      clr_btn = c;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_S"}, int'(S), 0);
    chk({tag, "_R"}, int'(R), 0);
    chk({tag, "_q_model"}, int'(q_model), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_conflict"}, int'(conflict), 0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    step(0, 0, 3);
    rst_n = 1'b1;

    // Clean set press, then release.
    step(1, 0, 12);
    step(0, 0, 12);

    // Bouncy set, then stable press.
    step(1, 0, 1); step(0, 0, 1); step(1, 0, 1); step(0, 0, 1);
    step(1, 0, 14);
    step(0, 0, 10);

    // Clear then set two cycles later, set lands during the R pulse.
    step(0, 1, 2);
    step(1, 1, 16);
    step(0, 0, 10);

    // Both rise on the same edge.
    step(1, 1, 14);
    step(0, 0, 12);

    // Randomized bouncy segments.
    for (int seg = 0; seg < 60; seg++) begin
      bit s, c;
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 3) == 0);
      step(s, c, $urandom_range(1, 12));
    end
    step(0, 0, 30);

    // Reset in the middle of an S pulse with the button held through reset.
    step(1, 0, 1);
    for (int i = 0; i < 40 && !S; i++) @(negedge clk);
    chk("s_seen_before_reset", int'(S), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_pulse_reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1, 0, 20);
    step(0, 0, 30);

    chk("expected_pulses_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
